// File: rtl/unpool_pkg.sv
// Shared widths, window constants and FSM encoding for the unpool block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`ifndef DESIGN_SIZE
`define DESIGN_SIZE 4
`endif
`ifndef DWIDTH
`define DWIDTH 8
`endif
`ifndef MAX_BITS_POOL
`define MAX_BITS_POOL 3
`endif

package unpool_pkg;

  localparam int DESIGN_SIZE   = `DESIGN_SIZE;
  localparam int DWIDTH        = `DWIDTH;
  localparam int MAX_BITS_POOL = `MAX_BITS_POOL;
  localparam int DATA_W        = DESIGN_SIZE * DWIDTH;

  localparam int WIN_1 = 1;
  localparam int WIN_2 = 2;
  localparam int WIN_4 = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } unpool_state_t;

  // Window kept as log2(W); anything other than 2 or 4 collapses to W=1.
  typedef logic [1:0] win_shift_t;

  function automatic win_shift_t win_to_shift(input logic [MAX_BITS_POOL-1:0] w);
    win_shift_t  s;
    int unsigned wv;
    wv = 32'(w);
    s  = 2'd0;
    if (wv == WIN_1)      s = 2'd0;
    else if (wv == WIN_2) s = 2'd1;
    else if (wv == WIN_4) s = 2'd2;
    return s;
  endfunction

endpackage

// File: rtl/unpool_replicate.sv
// Maps a buffered word, window and beat index to one nearest-neighbour output beat.
// Latency: purely combinational.
// Backpressure: none; caller holds inputs stable while a beat is stalled.
`ifndef DESIGN_SIZE
`define DESIGN_SIZE 4
`endif
`ifndef DWIDTH
`define DWIDTH 8
`endif
`ifndef MAX_BITS_POOL
`define MAX_BITS_POOL 3
`endif

module unpool_replicate
  import unpool_pkg::*;
(
  input  logic [DATA_W-1:0] word_buf,
  input  win_shift_t        win_shift,
  input  logic [1:0]        beat,
  output logic [DATA_W-1:0] beat_data
);

  int unsigned src;

  // Output element j of beat k comes from source element (k*DESIGN_SIZE + j) / W.
  always_comb begin
    beat_data = '0;
    src       = 0;
    for (int j = 0; j < DESIGN_SIZE; j++) begin
      src = ((32'(beat) * DESIGN_SIZE + j) >> win_shift) % DESIGN_SIZE;
      beat_data[j*DWIDTH +: DWIDTH] = word_buf[src*DWIDTH +: DWIDTH];
    end
  end

endmodule

// File: rtl/unpool.sv
// Nearest-neighbour unpooling: each accepted word is replayed as W beats (W = 1, 2 or 4).
// Latency: first beat valid one cycle after the word is accepted; bypass is combinational.
// Backpressure: valid/ready on both sides; new word accepted only as the last beat leaves.
`ifndef DESIGN_SIZE
`define DESIGN_SIZE 4
`endif
`ifndef DWIDTH
`define DWIDTH 8
`endif
`ifndef MAX_BITS_POOL
`define MAX_BITS_POOL 3
`endif

module unpool
  import unpool_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable_unpool,
  input  logic [`MAX_BITS_POOL-1:0]        unpool_window_size,
  input  logic [15:0]                      num_in_words,
  input  logic [`DESIGN_SIZE*`DWIDTH-1:0]  in_data,
  input  logic                             in_data_valid,
  output logic                             in_data_ready,
  output logic [`DESIGN_SIZE*`DWIDTH-1:0]  out_data,
  output logic                             out_data_valid,
  input  logic                             out_data_ready,
  output logic                             done_unpool
);

  unpool_state_t     state, state_nxt;
  logic [DATA_W-1:0] word_buf, word_buf_nxt;
  logic              buf_full, buf_full_nxt;
  win_shift_t        win_shift, win_shift_nxt;
  logic [1:0]        beat_cnt, beat_cnt_nxt;
  logic [15:0]       word_cnt, word_cnt_nxt;
  logic [15:0]       num_words, num_words_nxt;

  logic [DATA_W-1:0] beat_data;
  logic              last_beat;
  logic              last_word;
  logic              exp_out_vld;
  logic              exp_in_rdy;
  logic              out_fire;
  logic              in_fire;

  unpool_replicate u_replicate (
    .word_buf  (word_buf),
    .win_shift (win_shift),
    .beat      (beat_cnt),
    .beat_data (beat_data)
  );

  assign last_beat   = ({1'b0, beat_cnt} == ((3'd1 << win_shift) - 3'd1));
  assign last_word   = (word_cnt == num_words);
  assign exp_out_vld = (state == ST_EXPAND) && buf_full;
  assign out_fire    = exp_out_vld && out_data_ready;
  assign in_fire     = in_data_valid && exp_in_rdy;

  // Refill is allowed in the same cycle the last beat leaves, giving zero-bubble streaming.
  always_comb begin
    exp_in_rdy = 1'b0;
    case (state)
      ST_IDLE:   exp_in_rdy = 1'b1;
      ST_EXPAND: exp_in_rdy = !last_word && (!buf_full || (out_fire && last_beat));
      default:   exp_in_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      word_buf  <= '0;
      buf_full  <= 1'b0;
      win_shift <= '0;
      beat_cnt  <= '0;
      word_cnt  <= '0;
      num_words <= '0;
    end else begin
      state     <= state_nxt;
      word_buf  <= word_buf_nxt;
      buf_full  <= buf_full_nxt;
      win_shift <= win_shift_nxt;
      beat_cnt  <= beat_cnt_nxt;
      word_cnt  <= word_cnt_nxt;
      num_words <= num_words_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    word_buf_nxt  = word_buf;
    buf_full_nxt  = buf_full;
    win_shift_nxt = win_shift;
    beat_cnt_nxt  = beat_cnt;
    word_cnt_nxt  = word_cnt;
    num_words_nxt = num_words;

    if (!enable_unpool) begin
      state_nxt     = ST_IDLE;
      word_buf_nxt  = '0;
      buf_full_nxt  = 1'b0;
      win_shift_nxt = '0;
      beat_cnt_nxt  = '0;
      word_cnt_nxt  = '0;
      num_words_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_fire) begin
            state_nxt     = ST_EXPAND;
            word_buf_nxt  = in_data;
            buf_full_nxt  = 1'b1;
            win_shift_nxt = win_to_shift(unpool_window_size);
            beat_cnt_nxt  = '0;
            word_cnt_nxt  = 16'd1;
            num_words_nxt = (num_in_words == 16'd0) ? 16'd1 : num_in_words;
          end
        end
        ST_EXPAND: begin
          if (out_fire) begin
            if (last_beat) begin
              beat_cnt_nxt = '0;
              buf_full_nxt = 1'b0;
              if (last_word) state_nxt = ST_DONE;
            end else begin
              beat_cnt_nxt = beat_cnt + 2'd1;
            end
          end
          if (in_fire) begin
            word_buf_nxt  = in_data;
            buf_full_nxt  = 1'b1;
            win_shift_nxt = win_to_shift(unpool_window_size);
            beat_cnt_nxt  = '0;
            word_cnt_nxt  = word_cnt + 16'd1;
          end
        end
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Reset forces every output low, including the combinational bypass path.
  always_comb begin
    out_data       = '0;
    out_data_valid = 1'b0;
    in_data_ready  = 1'b0;
    done_unpool    = 1'b0;
    if (!reset) begin
      if (!enable_unpool) begin
        out_data       = in_data;
        out_data_valid = in_data_valid;
        in_data_ready  = out_data_ready;
        done_unpool    = 1'b1;
      end else begin
        out_data       = beat_data;
        out_data_valid = exp_out_vld;
        in_data_ready  = exp_in_rdy;
        done_unpool    = (state == ST_DONE);
      end
    end
  end

endmodule

// File: tb/tb_unpool.sv
// Scoreboarded bench for unpool: directed scenarios plus randomized operations.
// Expected beats come from a replicate-by-stream model; a separate monitor pops and compares.
`ifndef DESIGN_SIZE
`define DESIGN_SIZE 4
`endif
`ifndef DWIDTH
`define DWIDTH 8
`endif
`ifndef MAX_BITS_POOL
`define MAX_BITS_POOL 3
`endif

module tb_unpool;
  import unpool_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     enable_unpool;
  logic [MAX_BITS_POOL-1:0] unpool_window_size;
  logic [15:0]              num_in_words;
  logic [DATA_W-1:0]        in_data;
  logic                     in_data_valid;
  logic                     in_data_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_data_valid;
  logic                     out_data_ready;
  logic                     done_unpool;

  int checks   = 0;
  int failures = 0;
  int rdy_mode = 1;   // 0 random, 1 always high, 2 toggling
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  unpool dut (
    .clk                (clk),
    .reset              (reset),
    .enable_unpool      (enable_unpool),
    .unpool_window_size (unpool_window_size),
    .num_in_words       (num_in_words),
    .in_data            (in_data),
    .in_data_valid      (in_data_valid),
    .in_data_ready      (in_data_ready),
    .out_data           (out_data),
    .out_data_valid     (out_data_valid),
    .out_data_ready     (out_data_ready),
    .done_unpool        (done_unpool)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Model: stretch the element stream by W, then cut it into DESIGN_SIZE-wide beats.
  function automatic void push_expected(input logic [DATA_W-1:0] word, input int w_raw);
    int                w;
    logic [DWIDTH-1:0] stream[$];
    logic [DATA_W-1:0] beat;
    w = (w_raw == 1 || w_raw == 2 || w_raw == 4) ? w_raw : 1;
    for (int e = 0; e < DESIGN_SIZE; e++)
      for (int r = 0; r < w; r++)
        stream.push_back(word[e*DWIDTH +: DWIDTH]);
    for (int k = 0; k < w; k++) begin
      beat = '0;
      for (int j = 0; j < DESIGN_SIZE; j++)
        beat[j*DWIDTH +: DWIDTH] = stream[k*DESIGN_SIZE + j];
      exp_q.push_back(beat);
    end
  endfunction

  initial begin
    out_data_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_data_ready = ($urandom_range(0, 3) != 0);
        1:       out_data_ready = 1'b1;
        default: out_data_ready = ~out_data_ready;
      endcase
    end
  end

  // Monitor: compares transferred beats and enforces hold-while-stalled.
  initial begin
    logic              stalled;
    logic [DATA_W-1:0] held;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset || !enable_unpool) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid", 64'(out_data_valid), 64'd1);
          check("stall_data", 64'(out_data), 64'(held));
        end
        if (out_data_valid && out_data_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat got=%h exp=none", out_data);
          end else begin
            check("beat", 64'(out_data), 64'(exp_q.pop_front()));
          end
        end
        stalled = out_data_valid && !out_data_ready;
        held    = out_data;
      end
    end
  end

  task automatic end_op();
    @(negedge clk);
    enable_unpool = 1'b0;
    #1;
    check("end_bypass_done", 64'(done_unpool), 64'd1);
    @(negedge clk);
    enable_unpool = 1'b1;
    #1;
    check("end_idle_ready", 64'(in_data_ready), 64'd1);
    check("end_idle_done", 64'(done_unpool), 64'd0);
  endtask

  task automatic run_op(input int w, input int n, input bit rand_data);
    int neff;
    int waitc;
    bit acc;
    neff = (n == 0) ? 1 : n;
    @(negedge clk);
    unpool_window_size = MAX_BITS_POOL'(w);
    num_in_words       = 16'(n);
    for (int i = 0; i < neff; i++) begin
      in_data = rand_data ? DATA_W'($urandom) : DATA_W'(32'h04030201);
      while (rand_data && $urandom_range(0, 3) == 0) begin
        in_data_valid = 1'b0;
        @(negedge clk);
      end
      in_data_valid = 1'b1;
      acc   = 1'b0;
      waitc = 0;
      while (!acc && waitc < 200) begin
        #1;
        acc = in_data_ready;
        if (acc) push_expected(in_data, w);
        @(negedge clk);
        waitc++;
      end
      if (!acc) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout got=0 exp=1");
      end
      in_data_valid = 1'b0;
    end
    waitc = 0;
    #1;
    while (!done_unpool && waitc < 500) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    check("done_reached", 64'(done_unpool), 64'd1);
    check("done_ready_low", 64'(in_data_ready), 64'd0);
    check("done_valid_low", 64'(out_data_valid), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    end_op();
  endtask

  initial begin
    logic [DATA_W-1:0] words[3];
    int idx;

    reset              = 1'b1;
    enable_unpool      = 1'b1;
    unpool_window_size = MAX_BITS_POOL'(1);
    num_in_words       = 16'd1;
    in_data            = DATA_W'(32'h04030201);
    in_data_valid      = 1'b1;
    rdy_mode           = 1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_valid", 64'(out_data_valid), 64'd0);
    check("rst_done", 64'(done_unpool), 64'd0);
    check("rst_ready", 64'(in_data_ready), 64'd0);
    @(negedge clk);
    reset         = 1'b0;
    in_data_valid = 1'b0;
    #1;
    check("idle_ready", 64'(in_data_ready), 64'd1);
    check("idle_done", 64'(done_unpool), 64'd0);

    // W=1, single word: beat the cycle after accept, done one cycle after the beat
    @(negedge clk);
    in_data       = DATA_W'(32'h04030201);
    in_data_valid = 1'b1;
    #1;
    check("w1_accept", 64'(in_data_ready), 64'd1);
    if (in_data_ready) push_expected(in_data, 1);
    @(negedge clk);
    in_data_valid = 1'b0;
    #1;
    check("w1_valid", 64'(out_data_valid), 64'd1);
    check("w1_data", 64'(out_data), 64'h04030201);
    check("w1_not_done", 64'(done_unpool), 64'd0);
    @(negedge clk);
    #1;
    check("w1_done", 64'(done_unpool), 64'd1);
    check("w1_valid_drop", 64'(out_data_valid), 64'd0);
    end_op();

    // W=2 and W=4 with toggling backpressure
    run_op(2, 1, 1'b0);
    rdy_mode = 2;
    run_op(4, 1, 1'b0);
    rdy_mode = 1;

    // W=2, three words, valid held high: six beats with no bubbles
    for (int i = 0; i < 3; i++) words[i] = DATA_W'($urandom);
    idx = 0;
    @(negedge clk);
    unpool_window_size = MAX_BITS_POOL'(2);
    num_in_words       = 16'd3;
    in_data            = words[0];
    in_data_valid      = 1'b1;
    for (int t = 0; t <= 7; t++) begin
      #1;
      if (t <= 6) check("nb_ready", 64'(in_data_ready), 64'(t == 0 || t == 2 || t == 4));
      if (t >= 1 && t <= 6) check("nb_valid", 64'(out_data_valid), 64'd1);
      if (t == 7) check("nb_done", 64'(done_unpool), 64'd1);
      if (in_data_valid && in_data_ready) begin
        push_expected(in_data, 2);
        idx++;
      end
      @(negedge clk);
      if (idx < 3) in_data = words[idx];
      else in_data_valid = 1'b0;
    end
    check("nb_drained", 64'(exp_q.size()), 64'd0);
    end_op();

    // Reset after the first beat of a W=4 word aborts the word
    @(negedge clk);
    unpool_window_size = MAX_BITS_POOL'(4);
    num_in_words       = 16'd1;
    in_data            = DATA_W'(32'h04030201);
    in_data_valid      = 1'b1;
    #1;
    if (in_data_ready) push_expected(in_data, 4);
    @(negedge clk);
    in_data_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("abort_valid", 64'(out_data_valid), 64'd0);
    check("abort_ready", 64'(in_data_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      #1;
      check("abort_no_beat", 64'(out_data_valid), 64'd0);
      check("abort_idle_ready", 64'(in_data_ready), 64'd1);
      @(negedge clk);
    end

    // Disable mid-operation discards the buffer
    unpool_window_size = MAX_BITS_POOL'(4);
    num_in_words       = 16'd2;
    in_data_valid      = 1'b1;
    #1;
    if (in_data_ready) push_expected(in_data, 4);
    @(negedge clk);
    in_data_valid = 1'b0;
    @(negedge clk);
    enable_unpool = 1'b0;
    exp_q.delete();
    @(negedge clk);
    enable_unpool = 1'b1;
    #1;
    check("disable_valid", 64'(out_data_valid), 64'd0);
    check("disable_idle_ready", 64'(in_data_ready), 64'd1);

    // Bypass is combinational pass-through
    rdy_mode = 0;
    @(negedge clk);
    enable_unpool = 1'b0;
    in_data       = DATA_W'(32'hAABBCCDD);
    for (int t = 0; t < 4; t++) begin
      in_data_valid = (t != 2);
      #1;
      check("byp_data", 64'(out_data), 64'hAABBCCDD);
      check("byp_valid", 64'(out_data_valid), 64'(in_data_valid));
      check("byp_done", 64'(done_unpool), 64'd1);
      check("byp_ready", 64'(in_data_ready), 64'(out_data_ready));
      @(negedge clk);
    end
    in_data_valid = 1'b0;
    enable_unpool = 1'b1;

    // Randomized operations, including illegal windows and num_in_words = 0
    for (int r = 0; r < 12; r++)
      run_op($urandom_range(0, 7), $urandom_range(0, 4), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
